commit_trace_buffer: RTL and testbench

//  Sits beside the full-verilog difftest, on the same two DUT commit ports.

---
 rtl/commit_trace_buffer.sv | 188 ++++++++++++++++++
 tb/tb_commit_trace_buffer.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/commit_trace_buffer.sv
// commit_trace_buffer
// Keeps the PCs of the most recent TRACE_DEPTH committed instructions from a
// two-wide commit port in a ring buffer. A freeze request stops capture. The
// frozen trace can then be streamed, oldest entry first, over a valid/ready
// port as many times as needed. A clear empties the ring and restarts capture.

module commit_trace_buffer #(
    parameter int XLEN        = 64,
    parameter int TRACE_DEPTH = 64
) (
    input  logic                             clk_i,
    input  logic                             arst_i,
    input  logic                             commit0_valid_i,
    input  logic [XLEN-1:0]                  commit0_pc_i,
    input  logic                             commit1_valid_i,
    input  logic [XLEN-1:0]                  commit1_pc_i,
    input  logic                             freeze_i,
    input  logic                             dump_req_i,
    input  logic                             clear_i,
    output logic                             dump_valid_o,
    input  logic                             dump_ready_i,
    output logic [XLEN-1:0]                  dump_pc_o,
    output logic [$clog2(TRACE_DEPTH):0]     dump_idx_o,
    output logic                             dump_last_o,
    output logic                             dump_done_o,
    output logic [$clog2(TRACE_DEPTH):0]     count_o,
    output logic                             frozen_o,
    output logic [XLEN-1:0]                  total_commits_o
);

    localparam int AW = $clog2(TRACE_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(TRACE_DEPTH);

    typedef enum logic [1:0] {
        CAPTURE = 2'd0,
        FROZEN  = 2'd1,
        DUMP    = 2'd2
    } state_e;

    state_e          state_q, state_d;

    // Trace storage; contents are never reset, only the pointers are.
    logic [XLEN-1:0] traceRam_q [TRACE_DEPTH];

    logic [AW-1:0]   wrPtr_q, wrPtr_d;
    logic [CW-1:0]   count_q, count_d;
    logic [XLEN-1:0] total_q, total_d;

    logic [AW-1:0]   rdPtr_q, rdPtr_d;
    logic [CW-1:0]   dumpIdx_q, dumpIdx_d;
    logic            dumpValid_q, dumpValid_d;
    logic [XLEN-1:0] dumpPc_q, dumpPc_d;
    logic            dumpDone_q, dumpDone_d;

    logic            captureEn;
    logic            dualCommit;
    logic [1:0]      numCommits;
    logic [XLEN-1:0] singlePc;
    logic [CW:0]     countSum;
    logic [AW-1:0]   rdPtrNext;
    logic            handshake;
    logic            lastBeat;

    // Decode how many commits arrive this cycle and which PC a lone commit carries.
    always_comb begin
        captureEn  = (state_q == CAPTURE);
        dualCommit = commit0_valid_i && commit1_valid_i;
        numCommits = {1'b0, commit0_valid_i} + {1'b0, commit1_valid_i};
        singlePc   = commit0_valid_i ? commit0_pc_i : commit1_pc_i;
        countSum   = {1'b0, count_q} + (CW+1)'(numCommits);
        rdPtrNext  = rdPtr_q + AW'(1);
        handshake  = dumpValid_q && dump_ready_i;
        lastBeat   = (dumpIdx_q == (count_q - CW'(1)));
    end

    // Ring write port: the older slot always lands first, pointer wraps naturally.
    always_ff @(posedge clk_i) begin
        if (captureEn) begin
            if (dualCommit) begin
                traceRam_q[wrPtr_q]          <= commit0_pc_i;
                traceRam_q[wrPtr_q + AW'(1)] <= commit1_pc_i;
            end else if (numCommits != 2'd0) begin
                traceRam_q[wrPtr_q]          <= singlePc;
            end
        end
    end

    // Next-state logic for the capture/frozen/dump controller and its datapath.
    always_comb begin
        state_d     = state_q;
        wrPtr_d     = wrPtr_q;
        count_d     = count_q;
        total_d     = total_q;
        rdPtr_d     = rdPtr_q;
        dumpIdx_d   = dumpIdx_q;
        dumpValid_d = dumpValid_q;
        dumpPc_d    = dumpPc_q;
        dumpDone_d  = 1'b0;

        case (state_q)
            CAPTURE: begin
                wrPtr_d = wrPtr_q + AW'(numCommits);
                count_d = (countSum > {1'b0, DEPTH_C}) ? DEPTH_C : countSum[CW-1:0];
                total_d = total_q + XLEN'(numCommits);
                if (freeze_i) begin
                    state_d = FROZEN;
                end
            end

            FROZEN: begin
                if (clear_i) begin
                    state_d = CAPTURE;
                    wrPtr_d = '0;
                    count_d = '0;
                end else if (dump_req_i) begin
                    if (count_q != '0) begin
                        state_d   = DUMP;
                        rdPtr_d   = wrPtr_q - count_q[AW-1:0];
                        dumpIdx_d = '0;
                    end else begin
                        dumpDone_d = 1'b1;
                    end
                end
            end

            DUMP: begin
                if (!dumpValid_q) begin
                    dumpValid_d = 1'b1;
                    dumpPc_d    = traceRam_q[rdPtr_q];
                end else if (handshake) begin
                    if (lastBeat) begin
                        dumpValid_d = 1'b0;
                        dumpDone_d  = 1'b1;
                        dumpIdx_d   = '0;
                        state_d     = FROZEN;
                    end else begin
                        rdPtr_d   = rdPtrNext;
                        dumpIdx_d = dumpIdx_q + CW'(1);
                        dumpPc_d  = traceRam_q[rdPtrNext];
                    end
                end
            end

            default: begin
                state_d = CAPTURE;
            end
        endcase
    end

    // Controller and pointer registers; an async reset abandons any dump silently.
    always_ff @(posedge clk_i or negedge arst_i) begin
        if (!arst_i) begin
            state_q     <= CAPTURE;
            wrPtr_q     <= '0;
            count_q     <= '0;
            total_q     <= '0;
            rdPtr_q     <= '0;
            dumpIdx_q   <= '0;
            dumpValid_q <= 1'b0;
            dumpPc_q    <= '0;
            dumpDone_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            wrPtr_q     <= wrPtr_d;
            count_q     <= count_d;
            total_q     <= total_d;
            rdPtr_q     <= rdPtr_d;
            dumpIdx_q   <= dumpIdx_d;
            dumpValid_q <= dumpValid_d;
            dumpPc_q    <= dumpPc_d;
            dumpDone_q  <= dumpDone_d;
        end
    end

    // Output mapping; the last flag is qualified by valid so it is never seen idle.
    always_comb begin
        dump_valid_o    = dumpValid_q;
        dump_pc_o       = dumpPc_q;
        dump_idx_o      = dumpIdx_q;
        dump_last_o     = dumpValid_q && lastBeat;
        dump_done_o     = dumpDone_q;
        count_o         = count_q;
        frozen_o        = (state_q != CAPTURE);
        total_commits_o = total_q;
    end

endmodule

// File: tb/tb_commit_trace_buffer.sv
// tb_commit_trace_buffer
// Directed bench for commit_trace_buffer: capture, wrap, freeze-cycle commits,
// stalled and repeated dumps, empty dumps, clear, and reset in the middle of a dump.

module tb_commit_trace_buffer;

    localparam int XLEN  = 64;
    localparam int DEPTH = 64;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic            clk_i = 1'b0;
    logic            arst_i = 1'b1;
    logic            commit0_valid_i;
    logic [XLEN-1:0] commit0_pc_i;
    logic            commit1_valid_i;
    logic [XLEN-1:0] commit1_pc_i;
    logic            freeze_i;
    logic            dump_req_i;
    logic            clear_i;
    logic            dump_valid_o;
    logic            dump_ready_i;
    logic [XLEN-1:0] dump_pc_o;
    logic [CW-1:0]   dump_idx_o;
    logic            dump_last_o;
    logic            dump_done_o;
    logic [CW-1:0]   count_o;
    logic            frozen_o;
    logic [XLEN-1:0] total_commits_o;

    int              assertCount = 0;
    int              failCount   = 0;
    logic [XLEN-1:0] expQ [$];

    // Free-running clock, 10 time units per cycle.
    always #5 clk_i = ~clk_i;

    commit_trace_buffer #(
        .XLEN        (XLEN),
        .TRACE_DEPTH (DEPTH)
    ) dut (
        .clk_i           (clk_i),
        .arst_i          (arst_i),
        .commit0_valid_i (commit0_valid_i),
        .commit0_pc_i    (commit0_pc_i),
        .commit1_valid_i (commit1_valid_i),
        .commit1_pc_i    (commit1_pc_i),
        .freeze_i        (freeze_i),
        .dump_req_i      (dump_req_i),
        .clear_i         (clear_i),
        .dump_valid_o    (dump_valid_o),
        .dump_ready_i    (dump_ready_i),
        .dump_pc_o       (dump_pc_o),
        .dump_idx_o      (dump_idx_o),
        .dump_last_o     (dump_last_o),
        .dump_done_o     (dump_done_o),
        .count_o         (count_o),
        .frozen_o        (frozen_o),
        .total_commits_o (total_commits_o)
    );

    // One counted comparison, reported through an immediate assertion.
    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        assertCount++;
        assert (observed === expected)
        else begin
            failCount++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    // Drive one cycle of inputs at a negedge, let a posedge consume them, return at the next negedge.
    task automatic applyStimulus(input logic c0v, input logic [63:0] c0pc,
                                 input logic c1v, input logic [63:0] c1pc,
                                 input logic frz, input logic req, input logic clr);
        commit0_valid_i = c0v;
        commit0_pc_i    = c0pc;
        commit1_valid_i = c1v;
        commit1_pc_i    = c1pc;
        freeze_i        = frz;
        dump_req_i      = req;
        clear_i         = clr;
        @(posedge clk_i);
        @(negedge clk_i);
        commit0_valid_i = 1'b0;
        commit1_valid_i = 1'b0;
        freeze_i        = 1'b0;
        dump_req_i      = 1'b0;
        clear_i         = 1'b0;
    endtask

    // Every output must read zero while held in (or just out of) reset.
    task automatic checkIdleOutputs(input string tag);
        checkOutput({tag, "/valid"},  dump_valid_o, 0);
        checkOutput({tag, "/pc"},     dump_pc_o, 0);
        checkOutput({tag, "/idx"},    dump_idx_o, 0);
        checkOutput({tag, "/last"},   dump_last_o, 0);
        checkOutput({tag, "/done"},   dump_done_o, 0);
        checkOutput({tag, "/count"},  count_o, 0);
        checkOutput({tag, "/frozen"}, frozen_o, 0);
        checkOutput({tag, "/total"},  total_commits_o, 0);
    endtask

    // Pulse reset asynchronously and release it away from the rising edge.
    task automatic doReset();
        commit0_valid_i = 1'b0;
        commit1_valid_i = 1'b0;
        freeze_i        = 1'b0;
        dump_req_i      = 1'b0;
        clear_i         = 1'b0;
        dump_ready_i    = 1'b0;
        arst_i          = 1'b0;
        #2;
        @(negedge clk_i);
        arst_i = 1'b1;
        @(negedge clk_i);
    endtask

    // Request a dump of the frozen trace and compare every beat against expQ.
    task automatic runDump(input string tag, input bit toggleReady);
        int n;
        int beat;
        int cycles;
        bit readyPat [4];
        n      = expQ.size();
        beat   = 0;
        cycles = 0;
        readyPat = '{1'b1, 1'b0, 1'b0, 1'b1};
        applyStimulus(1'b0, 64'h0, 1'b0, 64'h0, 1'b0, 1'b1, 1'b0);
        checkOutput({tag, "/validDelayed"}, dump_valid_o, 0);
        checkOutput({tag, "/frozenInDump"}, frozen_o, 1);
        while (beat < n && cycles < 1000) begin
            dump_ready_i = toggleReady ? readyPat[cycles % 4] : 1'b1;
            if (dump_valid_o) begin
                checkOutput({tag, "/pc"},   dump_pc_o, expQ[beat]);
                checkOutput({tag, "/idx"},  dump_idx_o, 64'(beat));
                checkOutput({tag, "/last"}, dump_last_o, (beat == n - 1));
                if (dump_ready_i) begin
                    beat++;
                end
            end
            @(posedge clk_i);
            @(negedge clk_i);
            cycles++;
        end
        dump_ready_i = 1'b0;
        checkOutput({tag, "/beats"}, 64'(beat), 64'(n));
        if (!toggleReady) begin
            checkOutput({tag, "/cycles"}, 64'(cycles), 64'(n + 1));
        end
        checkOutput({tag, "/validDrop"}, dump_valid_o, 0);
        checkOutput({tag, "/donePulse"}, dump_done_o, 1);
        checkOutput({tag, "/frozenAfter"}, frozen_o, 1);
        applyStimulus(1'b0, 64'h0, 1'b0, 64'h0, 1'b0, 1'b0, 1'b0);
        checkOutput({tag, "/doneLow"}, dump_done_o, 0);
        checkOutput({tag, "/validIdle"}, dump_valid_o, 0);
    endtask

    // Safety net so a stuck design cannot hang the run.
    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog expired observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog");
    end

    // Directed test sequence.
    initial begin
        commit0_valid_i = 1'b0;
        commit0_pc_i    = '0;
        commit1_valid_i = 1'b0;
        commit1_pc_i    = '0;
        freeze_i        = 1'b0;
        dump_req_i      = 1'b0;
        clear_i         = 1'b0;
        dump_ready_i    = 1'b0;
        #2;

        // T1: reset values, three single commits, freeze, full-speed dump.
        $display("[TB] T1 basic capture and dump");
        arst_i = 1'b0;
        #2;
        checkIdleOutputs("t1InReset");
        @(negedge clk_i);
        arst_i = 1'b1;
        @(negedge clk_i);
        checkIdleOutputs("t1Released");
        applyStimulus(1'b1, 64'h8000_0000, 1'b0, 64'h0, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 64'h8000_0004, 1'b0, 64'h0, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 64'h0, 1'b1, 64'h8000_0008, 1'b0, 1'b0, 1'b0);
        checkOutput("t1Count", count_o, 3);
        checkOutput("t1Total", total_commits_o, 3);
        checkOutput("t1NotFrozen", frozen_o, 0);
        applyStimulus(1'b0, 64'h0, 1'b0, 64'h0, 1'b1, 1'b0, 1'b0);
        checkOutput("t1Frozen", frozen_o, 1);
        expQ = '{64'h8000_0000, 64'h8000_0004, 64'h8000_0008};
        runDump("t1Dump", 1'b0);
        checkOutput("t1CountKept", count_o, 3);

        // T2: 80 commits into a 64-entry ring; oldest 16 are overwritten.
        $display("[TB] T2 wrap and saturation");
        doReset();
        for (int k = 0; k < 40; k++) begin
            applyStimulus(1'b1, 64'h1000 + 64'(8 * k), 1'b1, 64'h1004 + 64'(8 * k),
                          1'b0, 1'b0, 1'b0);
        end
        checkOutput("t2CountSat", count_o, 64);
        checkOutput("t2Total", total_commits_o, 80);
        applyStimulus(1'b0, 64'h0, 1'b0, 64'h0, 1'b1, 1'b0, 1'b0);
        expQ.delete();
        for (int k = 16; k < 80; k++) begin
            expQ.push_back(64'h1000 + 64'(4 * k));
        end
        runDump("t2Dump", 1'b0);

        // T3: dual commit in the freeze cycle is kept, later commits are dropped.
        $display("[TB] T3 commits in freeze cycle");
        doReset();
        applyStimulus(1'b1, 64'h100, 1'b0, 64'h0, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 64'h200, 1'b1, 64'h204, 1'b1, 1'b0, 1'b0);
        checkOutput("t3Frozen", frozen_o, 1);
        checkOutput("t3Count", count_o, 3);
        applyStimulus(1'b1, 64'h300, 1'b1, 64'h304, 1'b1, 1'b0, 1'b0);
        checkOutput("t3CountHeld", count_o, 3);
        checkOutput("t3TotalHeld", total_commits_o, 3);

        // T4: stalled dump with a toggling ready, then an identical repeat.
        $display("[TB] T4 backpressure and repeat dump");
        expQ = '{64'h100, 64'h200, 64'h204};
        runDump("t4Stall", 1'b1);
        runDump("t4Repeat", 1'b1);

        // T5: empty dump, clear, resumed capture, clear beating dump request.
        $display("[TB] T5 empty dump and clear");
        doReset();
        applyStimulus(1'b0, 64'h0, 1'b0, 64'h0, 1'b1, 1'b0, 1'b0);
        checkOutput("t5Frozen", frozen_o, 1);
        applyStimulus(1'b0, 64'h0, 1'b0, 64'h0, 1'b0, 1'b1, 1'b0);
        checkOutput("t5EmptyDone", dump_done_o, 1);
        checkOutput("t5EmptyNoValid", dump_valid_o, 0);
        checkOutput("t5EmptyStillFrozen", frozen_o, 1);
        applyStimulus(1'b0, 64'h0, 1'b0, 64'h0, 1'b0, 1'b0, 1'b0);
        checkOutput("t5EmptyDoneLow", dump_done_o, 0);
        checkOutput("t5EmptyNoValidLater", dump_valid_o, 0);
        applyStimulus(1'b0, 64'h0, 1'b0, 64'h0, 1'b0, 1'b0, 1'b1);
        checkOutput("t5ClearUnfreezes", frozen_o, 0);
        applyStimulus(1'b1, 64'hA0, 1'b1, 64'hA4, 1'b0, 1'b0, 1'b0);
        checkOutput("t5ResumeCount", count_o, 2);
        applyStimulus(1'b0, 64'h0, 1'b0, 64'h0, 1'b1, 1'b0, 1'b0);
        expQ = '{64'hA0, 64'hA4};
        runDump("t5Resume", 1'b0);
        checkOutput("t5Total", total_commits_o, 2);
        applyStimulus(1'b0, 64'h0, 1'b0, 64'h0, 1'b0, 1'b1, 1'b1);
        checkOutput("t5ClearWinsFrozen", frozen_o, 0);
        checkOutput("t5ClearWinsCount", count_o, 0);
        checkOutput("t5ClearWinsTotal", total_commits_o, 2);
        applyStimulus(1'b0, 64'h0, 1'b1, 64'hB0, 1'b1, 1'b0, 1'b0);
        checkOutput("t5ClearWinsNoValid", dump_valid_o, 0);
        checkOutput("t5AfterClearCount", count_o, 1);
        expQ = '{64'hB0};
        runDump("t5AfterClear", 1'b0);
        checkOutput("t5FinalTotal", total_commits_o, 3);

        // T6: reset asserted while beat 2 of a five-beat dump is on the port.
        $display("[TB] T6 reset during dump");
        doReset();
        for (int k = 0; k < 5; k++) begin
            applyStimulus(1'b1, 64'h500 + 64'(4 * k), 1'b0, 64'h0, 1'b0, 1'b0, 1'b0);
        end
        applyStimulus(1'b0, 64'h0, 1'b0, 64'h0, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b0, 64'h0, 1'b0, 64'h0, 1'b0, 1'b1, 1'b0);
        dump_ready_i = 1'b1;
        @(posedge clk_i);
        @(negedge clk_i);
        checkOutput("t6Beat0Pc", dump_pc_o, 64'h500);
        @(posedge clk_i);
        @(negedge clk_i);
        checkOutput("t6Beat1Pc", dump_pc_o, 64'h504);
        @(posedge clk_i);
        @(negedge clk_i);
        checkOutput("t6Beat2Valid", dump_valid_o, 1);
        checkOutput("t6Beat2Idx", dump_idx_o, 2);
        checkOutput("t6Beat2Pc", dump_pc_o, 64'h508);
        arst_i = 1'b0;
        #1;
        checkIdleOutputs("t6MidDumpReset");
        dump_ready_i = 1'b0;
        @(negedge clk_i);
        checkOutput("t6NoDoneInReset", dump_done_o, 0);
        arst_i = 1'b1;
        @(negedge clk_i);
        checkIdleOutputs("t6Released");
        applyStimulus(1'b1, 64'h600, 1'b0, 64'h0, 1'b0, 1'b0, 1'b0);
        checkOutput("t6CaptureCount", count_o, 1);
        checkOutput("t6CaptureTotal", total_commits_o, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
